// File: rtl/gates_pkg.sv
// Shared definitions for the gate/mux/demux family.
//   buf_state_t : occupancy of a single-word output buffer
//   sel_width() : select-field width for an n-way block, never below 1 bit
package gates_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } buf_state_t;

    function automatic int sel_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmux_np_dec.sv
// dec_np: select index to N-bit one-hot decoder.
//   i_sel    : index to decode
//   o_onehot : bit i_sel set; all-zero when i_sel >= N
module dec_np
    import gates_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [N-1:0]     o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(i_sel) == k) begin
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmux_np.sv
// dmux_np: registered 1-to-N demultiplexer with per-port valid/ready.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_valid/o_ready  : upstream handshake, i_data routed to port i_sel
//   o_valid/i_ready  : per-port downstream handshake (at most one valid)
//   o_dmux           : per-port data, zero on ports not currently valid
//   o_drop           : one-cycle pulse after a word with i_sel >= N is discarded
module dmux_np
    import gates_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int D     = 16,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [D-1:0]     i_data,
    input  logic [SEL_W-1:0] i_sel,
    output logic [N-1:0]     o_valid,
    input  logic [N-1:0]     i_ready,
    output logic [D-1:0]     o_dmux [N-1:0],
    output logic             o_drop
);

    buf_state_t       state_q, state_d;
    logic [D-1:0]     data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             drop_q, drop_d;

    logic [N-1:0]     held_onehot;
    logic [N-1:0]     in_onehot;
    logic             in_range;
    logic             accept;
    logic             drain;

    dec_np #(.N(N), .SEL_W(SEL_W)) u_dec_held (
        .i_sel    (sel_q),
        .o_onehot (held_onehot)
    );

    // Second decoder doubles as the range check: no bit set means i_sel >= N.
    dec_np #(.N(N), .SEL_W(SEL_W)) u_dec_in (
        .i_sel    (i_sel),
        .o_onehot (in_onehot)
    );

    assign in_range = |in_onehot;
    assign o_valid  = (state_q == ST_FULL) ? held_onehot : '0;
    // Reducing over o_valid & i_ready picks i_ready[sel_q] without an index
    // that could fall outside the port range.
    assign drain    = |(o_valid & i_ready);
    assign o_ready  = (state_q == ST_EMPTY) | drain;
    assign accept   = i_valid & o_ready;
    assign o_drop   = drop_q;

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            o_dmux[k] = o_valid[k] ? data_q : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        drop_d  = 1'b0;
        if (accept && in_range) begin
            state_d = ST_FULL;
            data_d  = i_data;
            sel_d   = i_sel;
        end else if (accept) begin
            // Out-of-range word: when FULL, accept implies the held word drained.
            state_d = ST_EMPTY;
            drop_d  = 1'b1;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
        end
    end

endmodule
